// File: rtl/lsu_mem_master.sv
// Load/store initiator between the core and a word-organised data memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module lsu_mem_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_WE,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              f3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ADDR_WIDTH-1:0]   a_hold_q;
    logic                    err_q;
    logic                    accept;
    logic                    illegal;
    logic                    misaligned;
    logic                    mem_active;
    logic [ADDR_WIDTH-1:0]   word_addr;

    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [2:0]            f3,
        input logic [1:0]            off
    );
        logic [DATA_WIDTH-1:0]        lane;
        logic signed [7:0]            b;
        logic signed [15:0]           h;
        logic signed [DATA_WIDTH-1:0] r;
        lane = word >> {off, 3'b000};
        b    = lane[7:0];
        h    = lane[15:0];
        case (f3)
            3'b000:  r = b;
            3'b001:  r = h;
            3'b100:  r = DATA_WIDTH'(lane[7:0]);
            3'b101:  r = DATA_WIDTH'(lane[15:0]);
            default: r = word;
        endcase
        return r;
    endfunction

    // Byte or half of wdata substituted into its lane of the word just read.
    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [2:0]            f3,
        input logic [1:0]            off
    );
        logic [DATA_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] ins;
        if (f3[1:0] == 2'b00) begin
            mask = DATA_WIDTH'(8'hFF);
            ins  = DATA_WIDTH'(wdata[7:0]);
        end else begin
            mask = DATA_WIDTH'(16'hFFFF);
            ins  = DATA_WIDTH'(wdata[15:0]);
        end
        mask = mask << {off, 3'b000};
        ins  = ins << {off, 3'b000};
        return (word & ~mask) | ins;
    endfunction

    assign word_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111) || (req_funct3[2] && req_we);
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        accept     = 1'b0;
        mem_active = 1'b0;
        mem_WE     = 1'b0;
        mem_WD     = '0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = reset;
                accept    = req_valid && reset;
                if (accept) begin
                    if (illegal || misaligned)     state_d = RESP;
                    else if (!req_we)              state_d = LOAD;
                    else if (req_funct3 == 3'b010) state_d = WRITE;
                    else                           state_d = RMW_RD;
                end
            end
            LOAD: begin
                mem_active = 1'b1;
                state_d    = RESP;
            end
            RMW_RD: begin
                mem_active = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                mem_active = 1'b1;
                mem_WE     = 1'b1;
                mem_WD     = data_q;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_A     = mem_active ? word_addr : a_hold_q;
    assign rsp_rdata = rdata_q;

    // data_q starts as the SW payload and is replaced by the merged word on RMW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            a_hold_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                data_q  <= req_wdata;
                rdata_q <= '0;
                err_q   <= illegal || misaligned;
            end
            if (state_q == LOAD)
                rdata_q <= load_extend(mem_RD, f3_q, addr_q[1:0]);
            if (state_q == RMW_RD)
                data_q <= store_merge(mem_RD, wdata_q, f3_q, addr_q[1:0]);
            if (mem_active)
                a_hold_q <= word_addr;
        end
    end

endmodule
